pwm_multi_shadow: RTL and testbench
===================================

Name: pwm_multi_shadow

Overview:
Multi-channel PWM generator. It is the parametrised successor of the single-channel on/off-time PWM.
- One shared period counter with a programmable prescaler drives NCH compare channels.
- Each channel has its own duty value and output polarity.
- Period and duty values are double-buffered and only take effect at a period boundary, so a mid-period update cannot glitch an output.
- Sits between the register/config logic and the pad drivers of motor/LED outputs.

Parameters:
NCH, 4, number of PWM channels (1..16)
CNT_W, 16, period/duty counter width
PRE_W, 8, prescaler width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
en  in  1  counter run enable
prescale  in  PRE_W  one counter tick every prescale+1 clocks
period  in  CNT_W  staged period; cycle length is period+1 ticks
duty  in  NCH*CNT_W  staged duty per channel; channel i uses bits [i*CNT_W +: CNT_W]
pol  in  NCH  per-channel output inversion; live, not shadowed
upd_req  in  1  request to load staged period/duty into the shadows
upd_ack  out  1  one-clock pulse when the shadows are loaded
wrap  out  1  one-clock pulse on the tick where cnt returns to 0
cnt_out  out  CNT_W  current counter value
pwm_out  out  NCH  registered PWM outputs

Behaviour:
- Reset (rst=0, async):
  - Prescaler pc=0, cnt=0, period_sh=0, all duty_sh=0, pending=0.
  - upd_ack=0, wrap=0, pwm_out=0.
- Prescaler:
  - When en=1: pc increments each clk; tick=1 when pc==prescale, then pc<=0.
  - When en=0: pc holds at 0 and no ticks occur.
  - Changing prescale mid-run: if pc>prescale, pc wraps through 2^PRE_W-1 to 0 (modular); no special handling.
- Counter, on each tick:
  - If cnt>=period_sh: cnt<=0 and wrap=1 for that clk.
  - Otherwise: cnt<=cnt+1.
  - period_sh=0 means a wrap on every tick.
- Update handshake:
  - upd_req=1 in any clk sets pending.
  - Load event (period_sh<=period, duty_sh<=duty, pending<=0, upd_ack=1 for one clk) occurs on the first clk where pending or upd_req is set AND either (tick and the cnt>=period_sh condition holds) or en=0.
  - upd_req in the same clk as a wrapping tick loads at that wrap.
  - The new values govern from cnt=0 onwards.
  - Repeated upd_req while pending is held: a single load occurs, using the staged values present at the load clk.
- Compare:
  - pwm_out[i] <= (cnt < duty_sh[i]) ^ pol[i] each clk while en=1.
  - Output lags cnt by one clk.
  - duty_sh=0 gives constant inactive level.
  - duty_sh>period_sh gives constant active level.
  - Active time is duty_sh ticks per period_sh+1 ticks.
- Idle: with en=0, pwm_out[i] <= pol[i] (inactive level) and cnt holds its value. On re-enable, counting resumes from the held cnt.
- Arithmetic:
  - All compares are unsigned, CNT_W bits.
  - Maximum period is 2^CNT_W ticks; no overflow is possible because cnt never exceeds period_sh.
- Reset mid-operation: immediate return to reset values; the staged request is lost.

Optional Feature:
Macro PWM_CENTER_ALIGN_EN.
- Defined:
  - Adds input port `center` (1 bit). When center=1, the counter counts up 0..period_sh, then down to 0. The direction flag reverses at period_sh and at 0.
  - wrap and the shadow load occur only at the turnaround at 0. The period becomes 2*period_sh ticks, and the output is symmetric about period_sh.
  - With center=0, behaviour is identical to edge-aligned mode.
- Undefined: no `center` port and no direction logic; edge-aligned only.

Decomposition:
- Shared package `pwm_pkg`:
  - Default width constants: CNT_W_DEF=16, PRE_W_DEF=8.
  - Mode enum typedef pwm_mode_e {PWM_EDGE, PWM_CENTER}.
  - Duty-slice helper function.
- One natural sub-module, `pwm_cmp_ch`: per-channel duty shadow, compare and polarity register, instantiated NCH times in a generate loop. The prescaler, counter and handshake stay in the top.

Test Plan:
(All scenarios use NCH=2, CNT_W=8, PRE_W=4.)
1. prescale=0, period=9, duty={0,3}, pol=0, en=1, upd_req pulse → upd_ack within 1 clk. Thereafter wrap every 10 clks, ch0 high 3 clks per 10, ch1 constantly low.
2. Same setup with duty1=12 (>period) → ch1 constantly high. duty0=10 (=period+1) → ch0 constantly high.
3. prescale=3, period=9, duty0=3 → wrap every 40 clks, ch0 high 12 consecutive clks per period.
4. Running with duty0=3; at cnt=5 set duty0=7 and pulse upd_req → remainder of the current period uses duty 3. upd_ack coincides with the next wrap, and the following period has ch0 high 7 ticks.
5. rst driven 0 for 2 clks at cnt=6 → pwm_out, cnt_out, wrap and upd_ack are 0 immediately (before the next clk edge). After release, shadows are 0 and outputs stay low until an update.
6. pol=2'b11, en=0 → pwm_out=2'b11 and cnt frozen. Set en=1 with duty0=3 → ch0 low 3 ticks then high for the rest of the period (inverted).

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared widths, mode enum and duty-slice helper for the PWM blocks.
// Revision : 1.0
// ============================================================================
package pwm_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int PRE_W_DEF = 8;

    typedef enum logic [0:0] {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // LSB index of channel ch inside the packed duty bus
    function automatic int duty_lo(input int ch, input int cnt_w);
        return ch * cnt_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_cmp_ch.sv
`default_nettype none
// ============================================================================
// Module   : pwm_cmp_ch
// Brief    : One PWM channel: duty shadow register, compare and polarity.
// Revision : 1.0
// ============================================================================
module pwm_cmp_ch
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] duty,
    input  logic [CNT_W-1:0] cnt,
    input  logic             pol,
    output logic             pwm
);

    logic [CNT_W-1:0] r_duty_sh;
    logic             r_pwm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_duty_sh <= '0;
            r_pwm     <= 1'b0;
        end else begin
            if (load) begin
                r_duty_sh <= duty;
            end
            // Idle drives the inactive level, which is the polarity bit itself
            if (en) begin
                r_pwm <= (cnt < r_duty_sh) ^ pol;
            end else begin
                r_pwm <= pol;
            end
        end
    end

    assign pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_shadow.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_shadow
// Brief    : Multi-channel PWM, shared prescaled counter, shadowed period/duty.
//            Optional centre-aligned counting when PWM_CENTER_ALIGN_EN is set.
// Revision : 1.0
// ============================================================================
module pwm_multi_shadow
    import pwm_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRE_W-1:0]   prescale,
    input  logic [CNT_W-1:0]   period,
    input  logic [NCH*CNT_W-1:0] duty,
    input  logic [NCH-1:0]     pol,
    input  logic               upd_req,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic               center,
`endif
    output logic               upd_ack,
    output logic               wrap,
    output logic [CNT_W-1:0]   cnt_out,
    output logic [NCH-1:0]     pwm_out
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [PRE_W-1:0] c_pre_one = PRE_W'(1);

    logic [PRE_W-1:0] r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period_sh;
    logic             r_pending;
    logic             r_upd_ack;
    logic             r_wrap;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_tick;
    logic             w_at_end;
    logic             w_wrap_ev;
    logic             w_load;
    pwm_mode_e        w_mode;

    assign w_tick   = en && (r_pc == prescale);
    assign w_at_end = (r_cnt >= r_period_sh);

`ifdef PWM_CENTER_ALIGN_EN
    logic r_down;
    logic w_down_nxt;
    assign w_mode = center ? PWM_CENTER : PWM_EDGE;
`else
    assign w_mode = PWM_EDGE;
`endif

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_wrap_ev = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        w_down_nxt = r_down;
`endif
        case (w_mode)
`ifdef PWM_CENTER_ALIGN_EN
            PWM_CENTER: begin
                // Turn around at period_sh; only the return to 0 is a wrap
                if (w_tick) begin
                    if (r_down || w_at_end) begin
                        if (r_cnt <= c_cnt_one) begin
                            w_cnt_nxt  = '0;
                            w_down_nxt = 1'b0;
                            w_wrap_ev  = 1'b1;
                        end else begin
                            w_cnt_nxt  = r_cnt - c_cnt_one;
                            w_down_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
            end
`endif
            default: begin
`ifdef PWM_CENTER_ALIGN_EN
                w_down_nxt = 1'b0;
`endif
                if (w_tick) begin
                    if (w_at_end) begin
                        w_cnt_nxt = '0;
                        w_wrap_ev = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
            end
        endcase
    end

    // Shadows load at a period boundary, or at once while the counter is idle
    assign w_load = (r_pending || upd_req) && (w_wrap_ev || !en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc        <= '0;
            r_cnt       <= '0;
            r_period_sh <= '0;
            r_pending   <= 1'b0;
            r_upd_ack   <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            if (!en || (r_pc == prescale)) begin
                r_pc <= '0;
            end else begin
                r_pc <= r_pc + c_pre_one;
            end
            r_cnt     <= w_cnt_nxt;
            r_wrap    <= w_wrap_ev;
            r_upd_ack <= w_load;
            if (w_load) begin
                r_period_sh <= period;
                r_pending   <= 1'b0;
            end else if (upd_req) begin
                r_pending <= 1'b1;
            end
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_down <= 1'b0;
        end else begin
            r_down <= w_down_nxt;
        end
    end
`endif

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        pwm_cmp_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .load (w_load),
            .duty (duty[duty_lo(gi, CNT_W) +: CNT_W]),
            .cnt  (r_cnt),
            .pol  (pol[gi]),
            .pwm  (pwm_out[gi])
        );
    end

    assign upd_ack = r_upd_ack;
    assign wrap    = r_wrap;
    assign cnt_out = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_shadow.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi_shadow
// Brief    : Directed self-checking bench for pwm_multi_shadow (NCH=2, CNT_W=8).
// Revision : 1.0
// ============================================================================
module tb_pwm_multi_shadow;

    localparam int NCH   = 2;
    localparam int CNT_W = 8;
    localparam int PRE_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [PRE_W-1:0]   prescale;
    logic [CNT_W-1:0]   period;
    logic [NCH*CNT_W-1:0] duty;
    logic [NCH-1:0]     pol;
    logic               upd_req;
    logic               upd_ack;
    logic               wrap;
    logic [CNT_W-1:0]   cnt_out;
    logic [NCH-1:0]     pwm_out;

    int n_pass  = 0;
    int n_total = 0;

    int w_wraps, w_hi0, w_hi1, w_acks, w_run0, w_maxrun0;
    logic w_first0;

    always #5 clk = ~clk;

    pwm_multi_shadow #(
        .NCH   (NCH),
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .prescale (prescale),
        .period   (period),
        .duty     (duty),
        .pol      (pol),
        .upd_req  (upd_req),
`ifdef PWM_CENTER_ALIGN_EN
        .center   (1'b0),
`endif
        .upd_ack  (upd_ack),
        .wrap     (wrap),
        .cnt_out  (cnt_out),
        .pwm_out  (pwm_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic window(input int n);
        w_wraps = 0; w_hi0 = 0; w_hi1 = 0; w_acks = 0; w_run0 = 0; w_maxrun0 = 0;
        w_first0 = 1'bx;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) w_first0 = pwm_out[0];
            if (wrap)       w_wraps++;
            if (upd_ack)    w_acks++;
            if (pwm_out[1]) w_hi1++;
            if (pwm_out[0]) begin
                w_hi0++;
                w_run0++;
                if (w_run0 > w_maxrun0) w_maxrun0 = w_run0;
            end else begin
                w_run0 = 0;
            end
        end
    endtask

    task automatic wait_wrap(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (wrap) break;
        end
        if (!wrap) cyc = budget + 1;
    endtask

    task automatic wait_cnt(input string tag, input logic [CNT_W-1:0] v, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (cnt_out == v) found = 1'b1;
        end
        check(tag, found, 1'b1);
    endtask

    // upd_req must already be high; it is dropped after the first clock
    task automatic wait_ack(input int budget, output int iters, output logic wr, output int hi);
        iters = 0; hi = 0; wr = 1'b0;
        while (iters < budget) begin
            @(negedge clk);
            iters++;
            upd_req = 1'b0;
            if (pwm_out[0]) hi++;
            if (upd_ack) begin
                wr = wrap;
                break;
            end
        end
        if (!upd_ack) iters = budget + 1;
    endtask

    int   cyc, iters, hi;
    logic wr;

    initial begin
        rst = 1'b0; en = 1'b0; prescale = '0; period = '0; duty = '0;
        pol = '0; upd_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pwm", pwm_out, 0);
        check("rst_cnt", cnt_out, 0);
        check("rst_wrap", wrap, 0);
        check("rst_ack", upd_ack, 0);

        // 1: basic edge-aligned, prescale 0
        rst = 1'b1; en = 1'b1; prescale = 4'd0; period = 8'd9;
        duty = {8'd0, 8'd3}; upd_req = 1'b1;
        @(negedge clk);
        check("t1_ack", upd_ack, 1);
        check("t1_wrap_load", wrap, 1);
        check("t1_cnt0", cnt_out, 0);
        upd_req = 1'b0;
        window(20);
        check("t1_wraps", w_wraps, 2);
        check("t1_hi0", w_hi0, 6);
        check("t1_hi1", w_hi1, 0);
        check("t1_acks", w_acks, 0);
        wait_wrap(20, cyc);
        check("t1_wrap_period", cyc, 10);

        // 2: duty above period and equal to period+1
        duty = {8'd12, 8'd10}; upd_req = 1'b1;
        wait_ack(20, iters, wr, hi);
        check("t2_ack_latency", iters, 10);
        check("t2_ack_at_wrap", wr, 1);
        window(20);
        check("t2_hi0", w_hi0, 20);
        check("t2_hi1", w_hi1, 20);

        // 3: prescale 3, loaded while idle
        check("t3_cnt_start", cnt_out, 0);
        en = 1'b0; prescale = 4'd3; duty = {8'd0, 8'd3}; upd_req = 1'b1;
        @(negedge clk);
        check("t3_idle_ack", upd_ack, 1);
        check("t3_idle_pwm", pwm_out, 0);
        en = 1'b1; upd_req = 1'b0;
        wait_wrap(60, cyc);
        check("t3_first_wrap", cyc, 40);
        window(40);
        check("t3_hi0", w_hi0, 12);
        check("t3_run0", w_maxrun0, 12);
        check("t3_wraps", w_wraps, 1);

        // 4: mid-period update takes effect at next wrap
        prescale = 4'd0;
        wait_cnt("t4_reach5", 8'd5, 30);
        duty = {8'd0, 8'd7}; upd_req = 1'b1;
        wait_ack(20, iters, wr, hi);
        check("t4_ack_latency", iters, 5);
        check("t4_ack_at_wrap", wr, 1);
        check("t4_old_duty", hi, 0);
        window(10);
        check("t4_hi0", w_hi0, 7);
        check("t4_wraps", w_wraps, 1);

        // 5: asynchronous reset mid-period
        wait_cnt("t5_reach6", 8'd6, 30);
        check("t5_pre_pwm", pwm_out, 2'b01);
        rst = 1'b0;
        #1;
        check("t5_async_pwm", pwm_out, 0);
        check("t5_async_cnt", cnt_out, 0);
        check("t5_async_wrap", wrap, 0);
        check("t5_async_ack", upd_ack, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        window(10);
        check("t5_hi0", w_hi0, 0);
        check("t5_hi1", w_hi1, 0);
        check("t5_acks", w_acks, 0);
        check("t5_wraps", w_wraps, 10);
        check("t5_cnt", cnt_out, 0);

        // 6: inverted polarity, idle level and freeze/resume
        en = 1'b0; pol = 2'b11; duty = {8'd0, 8'd3}; upd_req = 1'b1;
        @(negedge clk);
        check("t6_ack", upd_ack, 1);
        check("t6_idle_pwm", pwm_out, 2'b11);
        upd_req = 1'b0;
        @(negedge clk);
        check("t6_idle_cnt", cnt_out, 0);
        en = 1'b1;
        window(10);
        check("t6_first0", w_first0, 0);
        check("t6_hi0", w_hi0, 7);
        check("t6_hi1", w_hi1, 10);
        check("t6_wraps", w_wraps, 1);
        wait_cnt("t6_reach4", 8'd4, 20);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_frozen_cnt", cnt_out, 4);
        check("t6_frozen_pwm", pwm_out, 2'b11);
        en = 1'b1;
        @(negedge clk);
        check("t6_resume_cnt", cnt_out, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
